// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the hazard / matmul controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  localparam int REG_AW_DEF = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mm_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Register addresses arrive zero-extended to 8 bits so one helper serves any REG_AW.
  function automatic logic [1:0] fwd_sel(
    input logic       regwrite_m,
    input logic [7:0] rd_m,
    input logic       regwrite_w,
    input logic [7:0] rd_w,
    input logic [7:0] rs_e
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (regwrite_m && (rd_m != 8'd0) && (rd_m == rs_e)) begin
      sel = FWD_M;
    end else if (regwrite_w && (rd_w != 8'd0) && (rd_w == rs_e)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_mm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_mm_ctrl_if
// Description : Pipeline-side signal bundle of the hazard / matmul controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_mm_ctrl_if #(
  parameter int REG_AW = hazard_pkg::REG_AW_DEF
);
  logic [REG_AW-1:0] rs1_d;
  logic [REG_AW-1:0] rs2_d;
  logic              is_matrix_mult_d;
  logic [REG_AW-1:0] rs1_e;
  logic [REG_AW-1:0] rs2_e;
  logic [REG_AW-1:0] rd_e;
  logic              memread_e;
  logic              pcsrc_e;
  logic [REG_AW-1:0] rd_m;
  logic              regwrite_m;
  logic [REG_AW-1:0] rd_w;
  logic              regwrite_w;

  logic              StallF;
  logic              StallD;
  logic              FlushD;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic              mm_start;
  logic              mm_busy;

  modport master (
    output rs1_d, rs2_d, is_matrix_mult_d, rs1_e, rs2_e, rd_e, memread_e,
           pcsrc_e, rd_m, regwrite_m, rd_w, regwrite_w,
    input  StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, mm_start, mm_busy
  );

  modport slave (
    input  rs1_d, rs2_d, is_matrix_mult_d, rs1_e, rs2_e, rd_e, memread_e,
           pcsrc_e, rd_m, regwrite_m, rd_w, regwrite_w,
    output StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, mm_start, mm_busy
  );
endinterface
`default_nettype wire

// File: rtl/hazard_mm_ctrl_mm_seq.sv
`default_nettype none
// ============================================================================
// Module      : mm_seq
// Description : Matrix-multiply sequencer: start pulse, busy flag, front-end hold.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_seq
  import hazard_pkg::*;
#(
  parameter int MM_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_abort,
  input  logic i_lwstall,
  input  logic i_mm_req,
  output logic o_mm_start,
  output logic o_mm_busy,
  output logic o_mm_hold
);

  localparam logic [7:0] c_CNT_INIT = 8'(MM_CYCLES - 1);

  mm_state_t  r_state;
  mm_state_t  w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_mm_start  = 1'b0;
    o_mm_busy   = 1'b0;
    o_mm_hold   = 1'b0;
    case (r_state)
      IDLE: begin
        // A redirect or a pending load-use hazard defers the launch.
        if (!i_abort && !i_lwstall && i_mm_req) begin
          o_mm_start  = 1'b1;
          o_mm_hold   = 1'b1;
          w_state_nxt = RUN;
          w_cnt_nxt   = c_CNT_INIT;
        end
      end
      RUN: begin
        o_mm_busy = 1'b1;
        if (i_abort) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt != 8'd0) begin
          o_mm_hold = 1'b1;
          w_cnt_nxt = r_cnt - 8'd1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/hazard_mm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_mm_ctrl
// Description : Pipeline hazard detection, forwarding and matmul front-end hold.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_mm_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW    = REG_AW_DEF,
  parameter int MM_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  hazard_mm_ctrl_if.slave  bus
);

  logic       w_lwstall;
  logic       w_mm_start;
  logic       w_mm_busy;
  logic       w_mm_hold;
  logic       w_stall;
  logic       w_flush_d;
  logic       w_flush_e;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  assign w_lwstall = bus.memread_e && (bus.rd_e != '0) &&
                     ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d));

  mm_seq #(
    .MM_CYCLES (MM_CYCLES)
  ) u_mm_seq (
    .clk        (clk),
    .reset      (reset),
    .i_abort    (bus.pcsrc_e),
    .i_lwstall  (w_lwstall),
    .i_mm_req   (bus.is_matrix_mult_d),
    .o_mm_start (w_mm_start),
    .o_mm_busy  (w_mm_busy),
    .o_mm_hold  (w_mm_hold)
  );

  assign w_fwd_a = fwd_sel(bus.regwrite_m, 8'(bus.rd_m), bus.regwrite_w,
                           8'(bus.rd_w), 8'(bus.rs1_e));
  assign w_fwd_b = fwd_sel(bus.regwrite_m, 8'(bus.rd_m), bus.regwrite_w,
                           8'(bus.rd_w), 8'(bus.rs2_e));

  // Redirect beats everything; load-use only matters while no matmul owns E.
  always_comb begin
    w_stall   = 1'b0;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    if (bus.pcsrc_e) begin
      w_flush_d = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_mm_hold) begin
      w_stall   = 1'b1;
      w_flush_e = 1'b1;
    end else if (w_lwstall && !w_mm_busy) begin
      w_stall   = 1'b1;
      w_flush_e = 1'b1;
    end
  end

  assign bus.StallF    = !reset && w_stall;
  assign bus.StallD    = !reset && w_stall;
  assign bus.FlushD    = !reset && w_flush_d;
  assign bus.FlushE    = !reset && w_flush_e;
  assign bus.ForwardAE = reset ? FWD_RF : w_fwd_a;
  assign bus.ForwardBE = reset ? FWD_RF : w_fwd_b;
  assign bus.mm_start  = !reset && w_mm_start;
  assign bus.mm_busy   = !reset && w_mm_busy;

endmodule
`default_nettype wire

// File: tb/tb_hazard_mm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_mm_ctrl
// Description : Directed plus randomized bench against a cycles-remaining model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_mm_ctrl;

  localparam int c_MM = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   busy_left;   // cycles the matmul still occupies, release cycle included
  logic obs_stalld;
  logic obs_start;
  logic obs_busy;
  logic obs_flushd;
  int   cnt_stall;
  int   cnt_start;
  int   cnt_busy;

  hazard_mm_ctrl_if #(.REG_AW(3)) bus ();

  hazard_mm_ctrl #(
    .REG_AW    (3),
    .MM_CYCLES (c_MM)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] exp_fwd(input logic [2:0] rs);
    if (bus.regwrite_m && bus.rd_m != 0 && bus.rd_m == rs) return 2'b10;
    if (bus.regwrite_w && bus.rd_w != 0 && bus.rd_w == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    bus.rs1_d = 0; bus.rs2_d = 0; bus.is_matrix_mult_d = 0;
    bus.rs1_e = 0; bus.rs2_e = 0; bus.rd_e = 0; bus.memread_e = 0;
    bus.pcsrc_e = 0; bus.rd_m = 0; bus.regwrite_m = 0;
    bus.rd_w = 0; bus.regwrite_w = 0;
  endtask

  // One clock: sample at negedge, compare with model, advance model at posedge.
  task automatic step(input string tag);
    logic       lw;
    logic [5:0] e;
    logic [5:0] o;
    int         nxt;
    @(negedge clk);
    lw  = bus.memread_e && bus.rd_e != 0 &&
          (bus.rd_e == bus.rs1_d || bus.rd_e == bus.rs2_d);
    e   = 6'b0;
    nxt = busy_left;
    if (busy_left > 0) begin
      e[0] = 1'b1;
      if (bus.pcsrc_e) begin
        e[3] = 1'b1; e[2] = 1'b1; nxt = 0;
      end else if (busy_left > 1) begin
        e[5] = 1'b1; e[4] = 1'b1; e[2] = 1'b1; nxt = busy_left - 1;
      end else begin
        nxt = 0;
      end
    end else if (bus.pcsrc_e) begin
      e[3] = 1'b1; e[2] = 1'b1;
    end else if (lw) begin
      e[5] = 1'b1; e[4] = 1'b1; e[2] = 1'b1;
    end else if (bus.is_matrix_mult_d) begin
      e[5] = 1'b1; e[4] = 1'b1; e[2] = 1'b1; e[1] = 1'b1; nxt = c_MM;
    end
    o = {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE, bus.mm_start, bus.mm_busy};
    chk({tag, "_ctrl"}, {2'b0, o}, {2'b0, e});
    chk({tag, "_fwdA"}, {6'b0, bus.ForwardAE}, {6'b0, exp_fwd(bus.rs1_e)});
    chk({tag, "_fwdB"}, {6'b0, bus.ForwardBE}, {6'b0, exp_fwd(bus.rs2_e)});
    obs_stalld = bus.StallD;
    obs_start  = bus.mm_start;
    obs_busy   = bus.mm_busy;
    obs_flushd = bus.FlushD;
    if (bus.StallD)   cnt_stall++;
    if (bus.mm_start) cnt_start++;
    if (bus.mm_busy)  cnt_busy++;
    @(posedge clk);
    #1;
    busy_left = nxt;
  endtask

  task automatic clear_counts();
    cnt_stall = 0; cnt_start = 0; cnt_busy = 0;
  endtask

  initial begin
    checks = 0; errors = 0; busy_left = 0;
    clear_counts();
    clear_inputs();
    reset = 1'b1;
    bus.rs1_e = 3; bus.rd_m = 3; bus.regwrite_m = 1; bus.is_matrix_mult_d = 1;
    #3;
    chk("reset_outputs", {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE,
                          bus.mm_start, bus.mm_busy, bus.ForwardAE}, 8'h00);
    @(posedge clk); #1;
    clear_inputs();
    reset = 1'b0;

    // Forwarding priority
    bus.rs1_e = 3; bus.rs2_e = 3; bus.rd_m = 3; bus.regwrite_m = 1;
    bus.rd_w = 3; bus.regwrite_w = 1;
    step("fwd_m");
    chk("fwdA_is_M", {6'b0, bus.ForwardAE}, 8'h02);
    bus.regwrite_m = 0;
    step("fwd_w");
    chk("fwdA_is_W", {6'b0, bus.ForwardAE}, 8'h01);
    bus.regwrite_m = 1; bus.rd_m = 0; bus.rd_w = 0;
    step("fwd_r0");
    chk("fwdB_is_RF", {6'b0, bus.ForwardBE}, 8'h00);
    clear_inputs();

    // Load-use
    bus.memread_e = 1; bus.rd_e = 2; bus.rs2_d = 2;
    step("lw_stall");
    chk("lw_stalld", {7'b0, obs_stalld}, 8'h01);
    bus.memread_e = 0;
    step("lw_clear");
    chk("lw_released", {7'b0, obs_stalld}, 8'h00);
    bus.memread_e = 1; bus.rd_e = 0; bus.rs2_d = 0;
    step("lw_r0");
    chk("lw_r0_nostall", {7'b0, obs_stalld}, 8'h00);
    clear_inputs();

    // Plain matmul: 8 stall cycles, one start, 8 busy cycles
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      bus.is_matrix_mult_d = (i < 9);
      step("mm");
    end
    chk("mm_stall_cnt", 8'(cnt_stall), 8'(c_MM));
    chk("mm_start_cnt", 8'(cnt_start), 8'd1);
    chk("mm_busy_cnt", 8'(cnt_busy), 8'(c_MM));
    clear_inputs();

    // Matmul coinciding with load-use
    clear_counts();
    for (int i = 0; i < 13; i++) begin
      bus.memread_e = (i == 0); bus.rd_e = 2; bus.rs1_d = 2;
      bus.is_matrix_mult_d = (i < 10);
      step("mm_lw");
      if (i == 0) chk("mm_lw_nostart", {7'b0, obs_start}, 8'h00);
    end
    chk("mm_lw_stall_cnt", 8'(cnt_stall), 8'(c_MM + 1));
    chk("mm_lw_start_cnt", 8'(cnt_start), 8'd1);
    clear_inputs();

    // Branch with matmul in D in IDLE
    bus.pcsrc_e = 1; bus.is_matrix_mult_d = 1;
    step("br_idle");
    chk("br_idle_flushd", {7'b0, obs_flushd}, 8'h01);
    chk("br_idle_nostart", {7'b0, obs_start}, 8'h00);
    bus.pcsrc_e = 0; bus.is_matrix_mult_d = 0;
    step("br_idle_after");
    chk("br_idle_notbusy", {7'b0, obs_busy}, 8'h00);

    // Branch injected mid-RUN
    bus.is_matrix_mult_d = 1;
    for (int i = 0; i < 4; i++) step("br_run_pre");
    bus.pcsrc_e = 1;
    step("br_run");
    chk("br_run_flushd", {7'b0, obs_flushd}, 8'h01);
    chk("br_run_nostall", {7'b0, obs_stalld}, 8'h00);
    bus.pcsrc_e = 0; bus.is_matrix_mult_d = 0;
    step("br_run_after");
    chk("br_run_aborted", {7'b0, obs_busy}, 8'h00);

    // Reset while RUN with cnt=4
    bus.is_matrix_mult_d = 1;
    for (int i = 0; i < 4; i++) step("rst_pre");
    bus.rs1_e = 3; bus.rd_m = 3; bus.regwrite_m = 1;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_outputs", {bus.StallF, bus.StallD, bus.FlushD, bus.FlushE,
                            bus.mm_start, bus.mm_busy, bus.ForwardAE}, 8'h00);
    busy_left = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    clear_inputs();
    clear_counts();
    for (int i = 0; i < 12; i++) begin
      bus.is_matrix_mult_d = (i < 9);
      step("mm_post_rst");
    end
    chk("post_rst_stall_cnt", 8'(cnt_stall), 8'(c_MM));
    clear_inputs();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.rs1_d = 3'($urandom); bus.rs2_d = 3'($urandom);
      bus.rs1_e = 3'($urandom); bus.rs2_e = 3'($urandom);
      bus.rd_e  = 3'($urandom); bus.rd_m  = 3'($urandom); bus.rd_w = 3'($urandom);
      bus.memread_e  = ($urandom_range(0, 3) == 0);
      bus.pcsrc_e    = ($urandom_range(0, 29) == 0);
      bus.is_matrix_mult_d = ($urandom_range(0, 4) == 0);
      bus.regwrite_m = 1'($urandom);
      bus.regwrite_w = 1'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_mm_ctrl.md
Name: hazard_mm_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage 8-bit pipeline. It generates StallF/StallD/FlushD/FlushE for the IF/ID and ID/EX pipeline registers, and operand-forwarding selects for the EX stage. It also runs the multi-cycle matrix-multiply sequencer: it holds the front end while the matrix unit computes, then releases the instruction into EX.

Parameters:
REG_AW, 3, register-address width (register 0 hardwired zero, never a hazard source)
MM_CYCLES, 8, matrix-unit latency in cycles; legal range 2..255

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
rs1_d  in  REG_AW  source reg 1 of instruction in D
rs2_d  in  REG_AW  source reg 2 of instruction in D
is_matrix_mult_d  in  1  instruction in D is a matrix multiply
rs1_e  in  REG_AW  source reg 1 in E
rs2_e  in  REG_AW  source reg 2 in E
rd_e  in  REG_AW  destination reg in E
memread_e  in  1  instruction in E is a load
pcsrc_e  in  1  taken branch/jump resolved in E
rd_m  in  REG_AW  destination reg in M
regwrite_m  in  1  M writes a register
rd_w  in  REG_AW  destination reg in W
regwrite_w  in  1  W writes a register
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX (bubble)
ForwardAE  out  2  EX operand A select: 00 regfile, 01 W result, 10 M result
ForwardBE  out  2  EX operand B select, same encoding
mm_start  out  1  one-cycle start pulse to matrix unit
mm_busy  out  1  sequencer in RUN

Behaviour:
- Reset (async): state=IDLE, cnt=0. While reset is high, all outputs are forced to 0.
- Forwarding (combinational, every state):
  - ForwardAE=10 if regwrite_m && rd_m!=0 && rd_m==rs1_e.
  - Else ForwardAE=01 if regwrite_w && rd_w!=0 && rd_w==rs1_e.
  - Else ForwardAE=00.
  - M has priority over W. ForwardBE is identical using rs2_e.
- lwstall = memread_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
- FSM states: IDLE, RUN. cnt is an 8-bit down-counter.
- IDLE, evaluated in priority order:
  1. pcsrc_e: FlushD=1, FlushE=1, no stall, no mm_start. Stay IDLE (a wrong-path matmul in D is discarded).
  2. lwstall: StallF=StallD=1, FlushE=1, no mm_start. Stay IDLE; the matmul, if present, retries next cycle.
  3. is_matrix_mult_d: mm_start=1, StallF=StallD=1, FlushE=1. Next state RUN, cnt<=MM_CYCLES-1.
  4. Otherwise all controls 0.
- RUN, mm_busy=1:
  - cnt!=0: StallF=StallD=1, FlushE=1, cnt<=cnt-1.
  - cnt==0: release (StallF=StallD=FlushE=0), next state IDLE. The matmul advances to E on this edge.
  - Front end is therefore held for exactly MM_CYCLES cycles, counting the start cycle.
- pcsrc_e during RUN is a protocol violation, since E holds bubbles. Required response: abort to IDLE, FlushD=1, FlushE=1, no stall.
- Stall and flush of the same register are never asserted together, except that FlushE accompanies StallD by design.
- mm_start never asserts in RUN; back-to-back matmuls are separated by at least the release cycle.

Decomposition:
- Shared package hazard_pkg:
  - state enum {IDLE, RUN}
  - forward-select constants FWD_RF=00, FWD_W=01, FWD_M=10
  - REG_AW default
- One natural sub-module, mm_seq: FSM plus counter, producing mm_start, mm_busy and mm_hold. The top level holds the hazard/forwarding combinational logic and output priority.

Test Plan:
- Forwarding: rs1_e=3, rd_m=3, regwrite_m=1, rd_w=3, regwrite_w=1 -> ForwardAE=10. Drop regwrite_m -> 01. Set rd_m=rd_w=0 -> 00.
- Load-use: memread_e=1, rd_e=2, rs2_d=2 -> StallF=StallD=FlushE=1 for exactly one cycle, then 0 once memread_e clears. With rd_e=0 -> no stall.
- Matmul, MM_CYCLES=8: is_matrix_mult_d=1 in IDLE -> mm_start high one cycle, StallD high cycles 0..7, released in cycle 8, mm_busy high cycles 1..8, then IDLE.
- Matmul plus load-use in the same cycle -> one stall cycle without mm_start, then mm_start the following cycle; total StallD = 1+8 cycles.
- pcsrc_e=1 with is_matrix_mult_d=1 in IDLE -> FlushD=FlushE=1, mm_start=0, state stays IDLE. pcsrc_e injected mid-RUN -> abort to IDLE next edge, FlushD=1.
- Reset asserted at RUN cnt=4 -> all outputs 0 immediately. After deassert, IDLE; a fresh matmul gives a full 8-cycle stall.
